// File: rtl/timer_sched_pkg.sv
// Shared types, default sizes and the wrap-safe expiry compare for the
// multi-channel compare-timer scheduler.
package timer_sched_pkg;

  localparam int unsigned DEF_N_CH = 4;
  localparam int unsigned DEF_CW   = 32;
  // Widest count the expiry helper accepts; callers zero-extend into it.
  localparam int unsigned MAX_CW   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } ch_state_t;

  // count has reached target when (count - target) is non-negative in cw-bit
  // two's complement. Zero-extension does not disturb the low cw bits of the
  // difference, so bit cw-1 of the wide result is the cw-bit sign.
  function automatic logic expired(input logic [MAX_CW-1:0] count,
                                   input logic [MAX_CW-1:0] target,
                                   input int unsigned       cw);
    logic [MAX_CW-1:0] diff;
    diff = count - target;
    return ~diff[6'(cw - 1)];
  endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// Register-decode / interrupt-side bundle of the timer scheduler.
interface timer_scheduler_if #(
  parameter int N_CH = 4,
  parameter int CW   = 32,
  parameter int CHW  = $clog2(N_CH)
);
  logic [CW-1:0]   count;
  logic            cfg_we;
  logic [CHW-1:0]  cfg_ch;
  logic            cfg_arm;
  logic            cfg_periodic;
  logic [CW-1:0]   cfg_limit;
  logic            ack_we;
  logic [CHW-1:0]  ack_ch;
  logic            irq;
  logic [CHW-1:0]  irq_ch;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] overrun;
  logic [N_CH-1:0] armed;

  // Register decode / tick source side
  modport master (
    output count, cfg_we, cfg_ch, cfg_arm, cfg_periodic, cfg_limit,
           ack_we, ack_ch,
    input  irq, irq_ch, pending, overrun, armed
  );

  // Scheduler side
  modport slave (
    input  count, cfg_we, cfg_ch, cfg_arm, cfg_periodic, cfg_limit,
           ack_we, ack_ch,
    output irq, irq_ch, pending, overrun, armed
  );
endinterface

// File: rtl/timer_sched_channel.sv
// One timer channel: target/limit registers, wrap-safe compare against the
// shared count, periodic reload, pending and sticky overrun flags.
module timer_sched_channel
  import timer_sched_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] count,
  input  logic          cfg_hit,
  input  logic          cfg_arm,
  input  logic          cfg_periodic,
  input  logic [CW-1:0] cfg_limit,
  input  logic          ack_hit,
  output logic          pending,
  output logic          overrun,
  output logic          armed
);

  ch_state_t     state;
  logic [CW-1:0] target;
  logic [CW-1:0] limit;
  logic          periodic;
  logic          fire;

  assign fire  = (state == ARMED) &&
                 expired(MAX_CW'(count), MAX_CW'(target), CW);
  assign armed = (state == ARMED);

  // Channel FSM. A cfg write owns the cycle outright (any coincident expiry
  // or ack is dropped); otherwise expiry wins over ack for pending, and an
  // ack in the expiry cycle suppresses the overrun it would have caused.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      target   <= '0;
      limit    <= '0;
      periodic <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else if (cfg_hit) begin
      pending <= 1'b0;
      overrun <= 1'b0;
      if (cfg_arm) begin
        state    <= ARMED;
        target   <= count + cfg_limit;
        limit    <= cfg_limit;
        periodic <= cfg_periodic;
      end else begin
        state <= IDLE;
      end
    end else if (fire) begin
      pending <= 1'b1;
      if (pending && !ack_hit) overrun <= 1'b1;
      // Reload from the old target, not from count, so period never drifts;
      // a late channel catches up one limit per cycle.
      if (periodic) target <= target + limit;
      else          state  <= FIRED;
    end else if (ack_hit) begin
      pending <= 1'b0;
      if (state == FIRED) state <= IDLE;
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// N_CH compare-timer channels sharing one free-running count, with cfg/ack
// index decode and a registered fixed-priority interrupt merge.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int CW   = DEF_CW,
  parameter int CHW  = $clog2(N_CH)
) (
  input  logic           clk,
  input  logic           rst,
  timer_scheduler_if.slave bus
);

  logic [N_CH-1:0] cfg_hit;
  logic [N_CH-1:0] ack_hit;
  logic [N_CH-1:0] pend_w;
  logic [N_CH-1:0] ovr_w;
  logic [N_CH-1:0] armed_w;
  logic [CHW-1:0]  enc_ch;
  logic            enc_vld;
  logic            irq_q;
  logic [CHW-1:0]  irq_ch_q;

  // Out-of-range indices match no channel and are dropped here.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign cfg_hit[i] = bus.cfg_we && (bus.cfg_ch == CHW'(i));
    assign ack_hit[i] = bus.ack_we && (bus.ack_ch == CHW'(i));

    timer_sched_channel #(.CW(CW)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .count        (bus.count),
      .cfg_hit      (cfg_hit[i]),
      .cfg_arm      (bus.cfg_arm),
      .cfg_periodic (bus.cfg_periodic),
      .cfg_limit    (bus.cfg_limit),
      .ack_hit      (ack_hit[i]),
      .pending      (pend_w[i]),
      .overrun      (ovr_w[i]),
      .armed        (armed_w[i])
    );
  end

  // Lowest pending index wins; 0 when nothing pending.
  always_comb begin
    enc_ch  = '0;
    enc_vld = |pend_w;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_w[i]) enc_ch = CHW'(i);
    end
  end

  // Interrupt merge is registered so irq/irq_ch depend only on flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q    <= 1'b0;
      irq_ch_q <= '0;
    end else begin
      irq_q    <= enc_vld;
      irq_ch_q <= enc_ch;
    end
  end

  assign bus.irq     = irq_q;
  assign bus.irq_ch  = irq_ch_q;
  assign bus.pending = pend_w;
  assign bus.overrun = ovr_w;
  assign bus.armed   = armed_w;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: count is driven explicitly per cycle,
// strobes are one-cycle pulses, outputs are checked 1ns after each edge.
module tb_timer_scheduler;

  localparam int N_CH = 4;
  localparam int CW   = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic seen;

  timer_scheduler_if #(.N_CH(N_CH), .CW(CW)) bus ();

  timer_scheduler #(.N_CH(N_CH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive count, take one edge, then drop any strobes raised for that edge.
  task automatic step(input logic [31:0] c);
    bus.count = c;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    bus.ack_we = 1'b0;
  endtask

  task automatic arm(input int ch, input logic per, input logic [31:0] lim,
                     input logic [31:0] c);
    bus.cfg_we       = 1'b1;
    bus.cfg_ch       = 2'(ch);
    bus.cfg_arm      = 1'b1;
    bus.cfg_periodic = per;
    bus.cfg_limit    = lim;
    step(c);
  endtask

  task automatic disarm(input int ch, input logic [31:0] c);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = 2'(ch);
    bus.cfg_arm = 1'b0;
    step(c);
  endtask

  task automatic ack(input int ch, input logic [31:0] c);
    bus.ack_we = 1'b1;
    bus.ack_ch = 2'(ch);
    step(c);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    bus.count = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_arm = 1'b0;
    bus.cfg_periodic = 1'b0; bus.cfg_limit = '0;
    bus.ack_we = 1'b0; bus.ack_ch = '0;

    // Reset state
    step(0); step(0);
    chk("rst_pending", 32'(bus.pending), 0);
    chk("rst_armed",   32'(bus.armed),   0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_irq",     32'(bus.irq),     0);
    chk("rst_irq_ch",  32'(bus.irq_ch),  0);
    rst = 1'b1;
    step(0);

    // One-shot ch1: armed at 100, limit 10 -> fires on the edge sampling 110
    arm(1, 1'b0, 10, 100);
    chk("os_armed", 32'(bus.armed), 32'b0010);
    for (int c = 101; c <= 109; c++) step(32'(c));
    chk("os_early", 32'(bus.pending), 0);
    step(110);
    chk("os_pend",     32'(bus.pending), 32'b0010);
    chk("os_irq_lag",  32'(bus.irq),     0);
    step(111);
    chk("os_irq",      32'(bus.irq),     1);
    chk("os_irq_ch",   32'(bus.irq_ch),  1);
    chk("os_fired",    32'(bus.armed),   0);
    ack(1, 112);
    chk("os_ack_pend", 32'(bus.pending), 0);
    chk("os_irq_hold", 32'(bus.irq),     1);
    step(113);
    chk("os_irq_clr",  32'(bus.irq),     0);
    chk("os_ch_clr",   32'(bus.irq_ch),  0);

    // Periodic ch0 across the count wrap: target 0x10, 0x30, 0x50
    arm(0, 1'b1, 32'h20, 32'hFFFF_FFF0);
    step(32'h0F); chk("pw_pre0",  32'(bus.pending), 0);
    step(32'h10); chk("pw_exp0",  32'(bus.pending), 32'b0001);
    ack(0, 32'h11); chk("pw_ack0", 32'(bus.pending), 0);
    step(32'h2F); chk("pw_pre1",  32'(bus.pending), 0);
    step(32'h30); chk("pw_exp1",  32'(bus.pending), 32'b0001);
    ack(0, 32'h31); chk("pw_ack1", 32'(bus.pending), 0);
    step(32'h4F); chk("pw_pre2",  32'(bus.pending), 0);
    step(32'h50); chk("pw_exp2",  32'(bus.pending), 32'b0001);
    chk("pw_no_ovr", 32'(bus.overrun), 0);
    chk("pw_armed",  32'(bus.armed),   32'b0001);
    disarm(0, 32'h51);
    chk("pw_disarm", 32'(bus.pending), 0);

    // Priority: ch2 and ch3 both hit target 1006
    arm(2, 1'b0, 6, 1000);
    arm(3, 1'b1, 5, 1001);
    step(1006); chk("pr_both",  32'(bus.pending), 32'b1100);
    step(1007); chk("pr_irq",   32'(bus.irq),     1);
                chk("pr_ch2",   32'(bus.irq_ch),  2);
    ack(2, 1008); chk("pr_ack2", 32'(bus.pending), 32'b1000);
    step(1009); chk("pr_ch3",   32'(bus.irq_ch),  3);
    step(1011); chk("pr_ovr",   32'(bus.overrun), 32'b1000);
    disarm(3, 1012);
    chk("pr_ovr_clr",  32'(bus.overrun), 0);
    chk("pr_pend_clr", 32'(bus.pending), 0);

    // Collisions: disarm beats expiry; ack with expiry keeps pending
    arm(0, 1'b0, 3, 2000);
    step(2001); step(2002);
    disarm(0, 2003);
    chk("co_dis_pend", 32'(bus.pending), 0);
    chk("co_dis_arm",  32'(bus.armed),   0);
    step(2004); chk("co_dis_late", 32'(bus.pending), 0);
    arm(1, 1'b1, 4, 2010);
    step(2014); chk("co_exp",   32'(bus.pending), 32'b0010);
    ack(1, 2018);
    chk("co_ackexp_pend", 32'(bus.pending), 32'b0010);
    chk("co_ackexp_ovr",  32'(bus.overrun), 0);
    ack(1, 2019); chk("co_ack", 32'(bus.pending), 0);
    disarm(1, 2020);

    // Limit 0 periodic: fires every cycle, overrun on the second expiry
    arm(0, 1'b1, 0, 3000);
    chk("l0_arm",  32'(bus.pending), 0);
    step(3001);
    chk("l0_p1",   32'(bus.pending), 32'b0001);
    chk("l0_o1",   32'(bus.overrun), 0);
    step(3002);
    chk("l0_o2",   32'(bus.overrun), 32'b0001);
    arm(0, 1'b1, 0, 3003);
    chk("l0_rearm_ovr",  32'(bus.overrun), 0);
    chk("l0_rearm_pend", 32'(bus.pending), 0);
    disarm(0, 3004);
    step(3005);

    // Asynchronous reset with channels armed and pending
    arm(1, 1'b0, 2, 4000);
    arm(2, 1'b1, 100, 4001);
    step(4002); chk("rs_pend", 32'(bus.pending), 32'b0010);
    step(4003); chk("rs_irq",  32'(bus.irq),     1);
    #2 rst = 1'b0;
    #1;
    chk("rs_async_pend", 32'(bus.pending), 0);
    chk("rs_async_arm",  32'(bus.armed),   0);
    chk("rs_async_irq",  32'(bus.irq),     0);
    chk("rs_async_ch",   32'(bus.irq_ch),  0);
    step(4004);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(32'(4005 + i));
      seen = seen | bus.irq | (|bus.pending);
    end
    chk("rs_quiet", 32'(seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
